// File: rtl/eth_axis_frame_gen.sv
// Ethernet frame generator feeding a 10G MAC AXI-Stream TX port.
// Frames carry DA/SA/ethertype and a counting payload. MAC completions are tracked for count and order.
module eth_axis_frame_gen #(
    parameter int DATA_W  = 64,
    parameter int KEEP_W  = DATA_W / 8,
    parameter int ID_W    = 8,
    parameter int USER_W  = 1,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [15:0]       cfg_frame_count,
    input  logic [15:0]       cfg_frame_len,
    input  logic [7:0]        cfg_ifg_cycles,
    input  logic [47:0]       cfg_eth_dst,
    input  logic [47:0]       cfg_eth_src,
    input  logic [15:0]       cfg_eth_type,
    input  logic [7:0]        cfg_seed,
    output logic [DATA_W-1:0] m_axis_tx_tdata,
    output logic [KEEP_W-1:0] m_axis_tx_tkeep,
    output logic              m_axis_tx_tvalid,
    input  logic              m_axis_tx_tready,
    output logic              m_axis_tx_tlast,
    output logic [USER_W-1:0] m_axis_tx_tuser,
    output logic [ID_W-1:0]   m_axis_tx_tid,
    input  logic              s_axis_cpl_tvalid,
    output logic              s_axis_cpl_tready,
    input  logic [ID_W-1:0]   s_axis_cpl_tid,
    input  logic [USER_W-1:0] s_axis_cpl_tuser,
    output logic              busy,
    output logic              done,
    output logic [31:0]       frames_sent,
    output logic [31:0]       frames_cpl,
    output logic [15:0]       cpl_err_cnt,
    output logic              cpl_seq_err
);

    localparam int SEQ_W = (ID_W > 8) ? ID_W : 8;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_IFG} state_t;
    state_t r_state, w_next;

    logic [13:0]       r_len;
    logic [15:0]       r_count;
    logic [7:0]        r_ifg, r_ifg_cnt;
    logic [47:0]       r_dst, r_src;
    logic [15:0]       r_type;
    logic [7:0]        r_seed;
    logic [10:0]       r_beat;
    logic [SEQ_W-1:0]  r_seq;
    logic              r_stop_seen;
    logic [ID_W-1:0]   r_exp_id, r_out;
    logic [31:0]       r_frames_sent, r_frames_cpl;
    logic [15:0]       r_cpl_err;
    logic              r_seq_err, r_done, r_cpl_rdy;

    logic [13:0]       w_len_clamped;
    logic [10:0]       w_last_idx;
    logic [KEEP_W-1:0] w_last_keep;
    logic [7:0]        w_base;
    logic              w_start, w_gate, w_valid, w_is_last, w_fire, w_fire_last;
    logic              w_stop_any, w_count_hit, w_cpl, w_cpl_dec;

    function automatic logic [7:0] f_byte(input logic [13:0] k, input logic [47:0] dst,
                                          input logic [47:0] src, input logic [15:0] typ,
                                          input logic [7:0] base);
        case (k)
            14'd0:   f_byte = dst[47:40];
            14'd1:   f_byte = dst[39:32];
            14'd2:   f_byte = dst[31:24];
            14'd3:   f_byte = dst[23:16];
            14'd4:   f_byte = dst[15:8];
            14'd5:   f_byte = dst[7:0];
            14'd6:   f_byte = src[47:40];
            14'd7:   f_byte = src[39:32];
            14'd8:   f_byte = src[31:24];
            14'd9:   f_byte = src[23:16];
            14'd10:  f_byte = src[15:8];
            14'd11:  f_byte = src[7:0];
            14'd12:  f_byte = typ[15:8];
            14'd13:  f_byte = typ[7:0];
            default: f_byte = k[7:0] - 8'd14 + base;
        endcase
    endfunction

    always_comb begin
        if (cfg_frame_len < 16'd14)
            w_len_clamped = 14'd14;
        else if (cfg_frame_len > 16'd16383)
            w_len_clamped = 14'd16383;
        else
            w_len_clamped = cfg_frame_len[13:0];
    end

    // Index of the last beat, i.e. ceil(len/8)-1
    assign w_last_idx  = r_len[13:3] - {10'd0, (r_len[2:0] == 3'd0)};
    assign w_last_keep = (r_len[2:0] == 3'd0) ? '1 : KEEP_W'((8'd1 << r_len[2:0]) - 8'd1);
    assign w_base      = r_seed + r_seq[7:0];

    assign w_start     = start && (r_state == S_IDLE);
    assign w_gate      = (r_beat == 11'd0) && (r_out >= ID_W'(MAX_OUT));
    assign w_valid     = (r_state == S_SEND) && !w_gate;
    assign w_is_last   = (r_beat == w_last_idx);
    assign w_fire      = w_valid && m_axis_tx_tready;
    assign w_fire_last = w_fire && w_is_last;
    assign w_stop_any  = r_stop_seen || stop;
    assign w_count_hit = (r_count != 16'd0) && ((r_frames_sent + 32'd1) == {16'd0, r_count});
    assign w_cpl       = s_axis_cpl_tvalid && r_cpl_rdy;
    assign w_cpl_dec   = w_cpl && (r_out != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_SEND;
            S_SEND: begin
                // A stop while held off by the outstanding limit ends the run without a beat shown
                if (w_gate && w_stop_any)
                    w_next = S_IDLE;
                else if (w_fire_last) begin
                    if (w_count_hit || w_stop_any)
                        w_next = S_IDLE;
                    else if (r_ifg != 8'd0)
                        w_next = S_IFG;
                end
            end
            S_IFG: if (r_ifg_cnt == 8'd0) w_next = w_stop_any ? S_IDLE : S_SEND;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        m_axis_tx_tvalid = w_valid;
        m_axis_tx_tdata  = '0;
        m_axis_tx_tkeep  = '0;
        m_axis_tx_tlast  = 1'b0;
        m_axis_tx_tid    = '0;
        m_axis_tx_tuser  = '0;
        busy             = (r_state != S_IDLE);
        if (r_state == S_SEND) begin
            for (int unsigned i = 0; i < 8; i++)
                m_axis_tx_tdata[8*i +: 8] = f_byte({r_beat, 3'(i)}, r_dst, r_src, r_type, w_base);
            m_axis_tx_tkeep = w_is_last ? w_last_keep : '1;
            m_axis_tx_tlast = w_is_last;
            m_axis_tx_tid   = r_seq[ID_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len         <= '0;
            r_count       <= '0;
            r_ifg         <= '0;
            r_ifg_cnt     <= '0;
            r_dst         <= '0;
            r_src         <= '0;
            r_type        <= '0;
            r_seed        <= '0;
            r_beat        <= '0;
            r_seq         <= '0;
            r_stop_seen   <= 1'b0;
            r_exp_id      <= '0;
            r_out         <= '0;
            r_frames_sent <= '0;
            r_frames_cpl  <= '0;
            r_cpl_err     <= '0;
            r_seq_err     <= 1'b0;
            r_done        <= 1'b0;
            r_cpl_rdy     <= 1'b1;
        end else begin
            r_cpl_rdy <= 1'b1;
            r_done    <= (r_state != S_IDLE) && (w_next == S_IDLE);

            if (w_start) begin
                r_len       <= w_len_clamped;
                r_count     <= cfg_frame_count;
                r_ifg       <= cfg_ifg_cycles;
                r_dst       <= cfg_eth_dst;
                r_src       <= cfg_eth_src;
                r_type      <= cfg_eth_type;
                r_seed      <= cfg_seed;
                r_beat      <= '0;
                r_stop_seen <= 1'b0;
            end else if (stop && (r_state != S_IDLE)) begin
                r_stop_seen <= 1'b1;
            end

            if (w_fire) begin
                r_beat <= w_is_last ? 11'd0 : r_beat + 11'd1;
            end
            if (w_fire_last) begin
                r_seq     <= r_seq + 1'b1;
                r_ifg_cnt <= r_ifg - 8'd1;
            end else if ((r_state == S_IFG) && (r_ifg_cnt != 8'd0)) begin
                r_ifg_cnt <= r_ifg_cnt - 8'd1;
            end

            if (w_start)
                r_frames_sent <= '0;
            else if (w_fire_last)
                r_frames_sent <= r_frames_sent + 32'd1;

            case ({w_fire_last, w_cpl_dec})
                2'b10:   r_out <= r_out + 1'b1;
                2'b01:   r_out <= r_out - 1'b1;
                default: r_out <= r_out;
            endcase
            if (w_cpl_dec)
                r_exp_id <= r_exp_id + 1'b1;

            if (w_start) begin
                r_frames_cpl <= '0;
                r_cpl_err    <= '0;
                r_seq_err    <= 1'b0;
            end else if (w_cpl) begin
                r_frames_cpl <= r_frames_cpl + 32'd1;
                if (s_axis_cpl_tuser[0] && (r_cpl_err != 16'hFFFF))
                    r_cpl_err <= r_cpl_err + 16'd1;
                if ((s_axis_cpl_tid != r_exp_id) || (r_out == '0))
                    r_seq_err <= 1'b1;
            end
        end
    end

    assign s_axis_cpl_tready = r_cpl_rdy;
    assign done              = r_done;
    assign frames_sent       = r_frames_sent;
    assign frames_cpl        = r_frames_cpl;
    assign cpl_err_cnt       = r_cpl_err;
    assign cpl_seq_err       = r_seq_err;

endmodule

// File: tb/tb_eth_axis_frame_gen.sv
// Directed-plus-random bench for eth_axis_frame_gen; accepted beats are compared against
// frames rebuilt from the byte-level frame rules, completions against a counter model.
module tb_eth_axis_frame_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0;
    logic [15:0] cfg_frame_count = '0, cfg_frame_len = '0;
    logic [7:0]  cfg_ifg_cycles = '0, cfg_seed = '0;
    logic [47:0] cfg_eth_dst = '0, cfg_eth_src = '0;
    logic [15:0] cfg_eth_type = '0;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid, tlast;
    logic        tready = 1'b1;
    logic [0:0]  tuser;
    logic [7:0]  tid;
    logic        cpl_tvalid = 1'b0;
    logic        cpl_tready;
    logic [7:0]  cpl_tid = '0;
    logic [0:0]  cpl_tuser = '0;
    logic        busy, done, cpl_seq_err;
    logic [31:0] frames_sent, frames_cpl;
    logic [15:0] cpl_err_cnt;

    eth_axis_frame_gen #(.DATA_W(64), .ID_W(8), .USER_W(1), .MAX_OUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_frame_count(cfg_frame_count), .cfg_frame_len(cfg_frame_len),
        .cfg_ifg_cycles(cfg_ifg_cycles), .cfg_eth_dst(cfg_eth_dst), .cfg_eth_src(cfg_eth_src),
        .cfg_eth_type(cfg_eth_type), .cfg_seed(cfg_seed),
        .m_axis_tx_tdata(tdata), .m_axis_tx_tkeep(tkeep), .m_axis_tx_tvalid(tvalid),
        .m_axis_tx_tready(tready), .m_axis_tx_tlast(tlast), .m_axis_tx_tuser(tuser),
        .m_axis_tx_tid(tid), .s_axis_cpl_tvalid(cpl_tvalid), .s_axis_cpl_tready(cpl_tready),
        .s_axis_cpl_tid(cpl_tid), .s_axis_cpl_tuser(cpl_tuser), .busy(busy), .done(done),
        .frames_sent(frames_sent), .frames_cpl(frames_cpl), .cpl_err_cnt(cpl_err_cnt),
        .cpl_seq_err(cpl_seq_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [7:0]  id;
        int          c;
    } beat_t;

    beat_t beats[$];
    int    done_q[$];
    int    cyc = 0;
    int    n_assert = 0, n_fail = 0;
    bit    rand_ready = 1'b0;
    bit    prev_stall = 1'b0;
    logic [63:0] prev_d;
    logic [16:0] prev_ctl;

    int m_seq, m_out, m_exp, m_cpl, m_errcnt;
    bit m_seqerr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_valid", 64'(tvalid), 64'd1);
                chk("stall_data", tdata, prev_d);
                chk("stall_ctl", 64'({tkeep, tlast, tid}), 64'(prev_ctl));
            end
            if (tvalid && tready) beats.push_back('{tdata, tkeep, tlast, tid, cyc});
            if (done) done_q.push_back(cyc);
        end
        prev_stall = rst_n && tvalid && !tready;
        prev_d     = tdata;
        prev_ctl   = {tkeep, tlast, tid};
    end

    initial forever begin
        @(posedge clk);
        #1;
        tready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; cpl_tvalid = 1'b0; rand_ready = 1'b0;
        repeat (3) step();
        beats.delete(); done_q.delete();
        m_seq = 0; m_out = 0; m_exp = 0; m_cpl = 0; m_errcnt = 0; m_seqerr = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic start_run(input int len, input int count, input int ifg, output int s);
        logic [63:0] t;
        t = {$urandom(), $urandom()}; cfg_eth_dst = t[47:0];
        t = {$urandom(), $urandom()}; cfg_eth_src = t[47:0];
        cfg_eth_type = 16'($urandom()); cfg_seed = 8'($urandom());
        cfg_frame_len = 16'(len); cfg_frame_count = 16'(count); cfg_ifg_cycles = 8'(ifg);
        start = 1'b1;
        s = cyc;
        step();
        start = 1'b0;
        m_cpl = 0; m_errcnt = 0; m_seqerr = 1'b0;
    endtask

    function automatic logic [7:0] exp_byte(input int k, input int seq);
        logic [47:0] t;
        if (k < 6) begin t = cfg_eth_dst >> (8 * (5 - k)); return t[7:0]; end
        if (k < 12) begin t = cfg_eth_src >> (8 * (11 - k)); return t[7:0]; end
        if (k == 12) return cfg_eth_type[15:8];
        if (k == 13) return cfg_eth_type[7:0];
        return 8'((k - 14 + int'(cfg_seed) + seq) % 256);
    endfunction

    task automatic check_frame(input int len, input string tag, output int c0, output int cl);
        int nb, t, rem;
        beat_t b;
        logic [63:0] ed, md;
        logic [7:0] ek;
        nb = (len + 7) / 8; t = 0; c0 = -1; cl = -1;
        while (beats.size() < nb && t < 4000) begin step(); t++; end
        if (beats.size() < nb) begin
            chk({tag, "_timeout"}, 64'(beats.size()), 64'(nb));
            return;
        end
        for (int i = 0; i < nb; i++) begin
            b = beats.pop_front();
            if (i == 0) c0 = b.c;
            if (i == nb - 1) cl = b.c;
            rem = len - 8 * i;
            ek = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
            ed = '0; md = '0;
            for (int j = 0; j < 8; j++) begin
                if (j < rem) ed[8*j +: 8] = exp_byte(8 * i + j, m_seq);
                if (b.k[j]) md[8*j +: 8] = b.d[8*j +: 8];
            end
            chk({tag, "_data"}, md, ed);
            chk({tag, "_keep"}, 64'(b.k), 64'(ek));
            chk({tag, "_last"}, 64'(b.l), 64'(i == nb - 1));
            chk({tag, "_tid"}, 64'(b.id), 64'(m_seq % 256));
        end
        m_seq++;
        m_out++;
    endtask

    task automatic wait_done(input int budget, output int dc);
        int t = 0;
        while (done_q.size() == 0 && t < budget) begin step(); t++; end
        if (done_q.size() == 0) begin
            chk("done_timeout", 64'd0, 64'd1);
            dc = -1;
        end else begin
            dc = done_q.pop_front();
        end
    endtask

    task automatic send_cpl(input int id, input bit err);
        bit e;
        cpl_tvalid = 1'b1; cpl_tid = 8'(id); cpl_tuser = err;
        step();
        cpl_tvalid = 1'b0; cpl_tuser = 1'b0;
        e = (id != m_exp) || (m_out == 0);
        if (m_out != 0) begin m_exp = (m_exp + 1) % 256; m_out--; end
        m_seqerr |= e;
        m_cpl++;
        if (err && m_errcnt < 65535) m_errcnt++;
        chk("cpl_count", 64'(frames_cpl), 64'(m_cpl));
        chk("cpl_err_cnt", 64'(cpl_err_cnt), 64'(m_errcnt));
        chk("cpl_seq_err", 64'(cpl_seq_err), 64'(m_seqerr));
    endtask

    int s, dc, c0, cl, t;
    int f0[3], fl[3];

    initial begin
        // reset state
        do_reset();
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_tkeep_last_tid_tuser", 64'({tkeep, tlast, tid, tuser}), 64'd0);
        chk("rst_cpl_tready", 64'(cpl_tready), 64'd1);
        chk("rst_busy_done", 64'({busy, done, cpl_seq_err}), 64'd0);
        chk("rst_counters", 64'({frames_sent, frames_cpl}), 64'd0);
        chk("rst_err_cnt", 64'(cpl_err_cnt), 64'd0);

        // single 64-byte frame, latency and done timing
        start_run(64, 1, 0, s);
        chk("t1_busy", 64'(busy), 64'd1);
        check_frame(64, "t1", c0, cl);
        chk("t1_first_cyc", 64'(c0), 64'(s + 1));
        chk("t1_last_cyc", 64'(cl), 64'(s + 8));
        wait_done(50, dc);
        chk("t1_done_cyc", 64'(dc), 64'(s + 9));
        chk("t1_frames_sent", 64'(frames_sent), 64'd1);
        chk("t1_busy_end", 64'(busy), 64'd0);

        // three 61-byte frames with 4-cycle gap
        do_reset();
        start_run(61, 3, 4, s);
        for (int f = 0; f < 3; f++) check_frame(61, "t2", f0[f], fl[f]);
        for (int f = 1; f < 3; f++) chk("t2_gap", 64'(f0[f] - fl[f-1]), 64'd5);
        wait_done(50, dc);
        chk("t2_frames_sent", 64'(frames_sent), 64'd3);

        // backpressure with random tready
        do_reset();
        rand_ready = 1'b1;
        start_run(60, 2, 1, s);
        check_frame(60, "t3a", c0, cl);
        check_frame(60, "t3b", c0, cl);
        wait_done(100, dc);
        rand_ready = 1'b0;
        chk("t3_frames_sent", 64'(frames_sent), 64'd2);

        // outstanding limit: four frames, then hold until a completion
        do_reset();
        start_run(16, 0, 0, s);
        for (int f = 0; f < 4; f++) check_frame(16, "t4", c0, cl);
        repeat (20) step();
        chk("t4_held_sent", 64'(frames_sent), 64'd4);
        chk("t4_held_tvalid", 64'(tvalid), 64'd0);
        chk("t4_held_busy", 64'(busy), 64'd1);
        chk("t4_no_beats", 64'(beats.size()), 64'd0);
        send_cpl(0, 1'b0);
        check_frame(16, "t4_fifth", c0, cl);
        repeat (10) step();
        chk("t4_fifth_sent", 64'(frames_sent), 64'd5);
        chk("t4_regated", 64'(tvalid), 64'd0);
        stop = 1'b1; step(); stop = 1'b0;
        wait_done(20, dc);
        chk("t4_stop_idle", 64'(busy), 64'd0);

        // completion errors, start clearing, length clamp, seq continuity
        send_cpl(1, 1'b1);
        send_cpl(3, 1'b0);
        start_run(5, 1, 0, s);
        chk("t5_clr_seq_err", 64'(cpl_seq_err), 64'd0);
        chk("t5_clr_err_cnt", 64'(cpl_err_cnt), 64'd0);
        chk("t5_clr_cpl", 64'(frames_cpl), 64'd0);
        check_frame(14, "t5_clamp", c0, cl);
        wait_done(20, dc);
        send_cpl(3, 1'b0);
        send_cpl(4, 1'b0);
        send_cpl(5, 1'b0);
        send_cpl(6, 1'b0);

        // continuous run stopped mid frame 3
        do_reset();
        start_run(64, 0, 0, s);
        t = 0;
        while (frames_sent != 32'd3 && t < 200) begin step(); t++; end
        chk("t6_reach3", 64'(frames_sent), 64'd3);
        repeat (3) step();
        stop = 1'b1; step(); stop = 1'b0;
        for (int f = 0; f < 4; f++) check_frame(64, "t6", c0, cl);
        wait_done(50, dc);
        chk("t6_frames_sent", 64'(frames_sent), 64'd4);
        chk("t6_idle", 64'(busy), 64'd0);
        repeat (5) step();
        chk("t6_no_more", 64'(beats.size()), 64'd0);

        // asynchronous reset in the middle of a frame
        do_reset();
        start_run(64, 1, 0, s);
        repeat (3) step();
        chk("t7_midframe", 64'(tvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_tvalid", 64'(tvalid), 64'd0);
        chk("t7_tdata", tdata, 64'd0);
        chk("t7_ctl", 64'({tkeep, tlast, tid, busy, done}), 64'd0);
        chk("t7_counters", 64'({frames_sent, frames_cpl}), 64'd0);
        chk("t7_cpl_tready", 64'(cpl_tready), 64'd1);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
